if_fetch: RTL and testbench

- Instruction-fetch stage. It sits directly upstream of the stall controller's IF/ID consumers and is gated by the controller's `stall` vector.
- Owns the PC and fetches each 32-bit instruction as four byte reads over the shared byte-wide memory port. The port is arbitrated by the memory controller.
- Presents `{if_pc, if_inst, if_valid}` to the IF/ID register and restarts on jump redirects from ID.

---
 rtl/if_fetch_pkg.sv | 21 ++
 rtl/if_byte_asm.sv | 49 ++++
 rtl/if_fetch.sv | 124 ++++++++++++
 tb/tb_if_fetch.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

   localparam int unsigned INST_W       = 32;
   localparam int unsigned ADDR_W_DEF   = 32;
   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned INST_BYTES   = INST_W / BYTE_W;
   localparam int unsigned CNT_W        = 3;
   localparam int unsigned STALL_W      = 6;
   localparam int unsigned STOP_ISSUE   = 0;
   localparam int unsigned STOP_OUT     = 1;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic {
      IF_FETCH = 1'b0,
      IF_OUT   = 1'b1
   } if_state_e;

   typedef logic [1:0] byte_idx_t;

endpackage

// File: rtl/if_byte_asm.sv
// Tracks the one outstanding byte read and assembles bytes 0..2 of the instruction;
// byte 3 is forwarded straight from the memory port when it arrives.
module if_byte_asm
   import if_fetch_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                cap_en,
   input  byte_idx_t           cap_idx,
   input  logic [BYTE_W-1:0]   byte_in,
   input  logic                flush,
   output logic [INST_W-1:0]   word_c,
   output logic                done_c
);

   logic                       inflight_q, inflight_d;
   byte_idx_t                  tag_q, tag_d;
   logic [INST_W-BYTE_W-1:0]   asm_q, asm_d;

   always_comb begin
      inflight_d = cap_en & ~flush;
      tag_d      = cap_en ? cap_idx : tag_q;
      asm_d      = asm_q;
      if (inflight_q) begin
         case (tag_q)
            2'd0:    asm_d[7:0]   = byte_in;
            2'd1:    asm_d[15:8]  = byte_in;
            2'd2:    asm_d[23:16] = byte_in;
            default: asm_d        = asm_q;
         endcase
      end
   end

   assign done_c = inflight_q && (tag_q == 2'd3);
   assign word_c = {byte_in, asm_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= 1'b0;
         tag_q      <= 2'd0;
         asm_q      <= '0;
      end else begin
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
         asm_q      <= asm_d;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches each instruction as four byte reads
// and presents {if_pc, if_inst, if_valid} to IF/ID; ID jumps override everything.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [STALL_W-1:0]  stall,
   input  logic                jump_en,
   input  logic [ADDR_W-1:0]   jump_target,
   input  logic                mem_busy,
   input  logic [BYTE_W-1:0]   mem_din,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   if_pc,
   output logic [INST_W-1:0]   if_inst,
   output logic                if_valid
);

   if_state_e             state_q, state_d;
   logic [ADDR_W-1:0]     pc_q, pc_d;
   logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
   logic [ADDR_W-1:0]     if_pc_q, if_pc_d;
   logic [INST_W-1:0]     if_inst_q, if_inst_d;
   logic                  if_valid_q, if_valid_d;

   logic                  issue_c;
   logic [ADDR_W-1:0]     mem_addr_c;
   logic                  flush_c;
   logic [INST_W-1:0]     word_c;
   logic                  done_c;
   logic                  unused_stall;

   assign unused_stall = ^stall[STALL_W-1:2];

   if_byte_asm u_byte_asm (
      .clk     (clk),
      .rst     (rst),
      .cap_en  (issue_c),
      .cap_idx (issue_cnt_q[1:0]),
      .byte_in (mem_din),
      .flush   (flush_c),
      .word_c  (word_c),
      .done_c  (done_c)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      issue_cnt_d = issue_cnt_q;
      if_pc_d     = if_pc_q;
      if_inst_d   = if_inst_q;
      if_valid_d  = if_valid_q;
      flush_c     = 1'b0;
      mem_addr_c  = pc_q;

      issue_c = (state_q == IF_FETCH) && (issue_cnt_q < CNT_W'(INST_BYTES)) &&
                !mem_busy && !stall[STOP_ISSUE] && !jump_en;

      if (issue_c) begin
         mem_addr_c  = pc_q + ADDR_W'(issue_cnt_q);
         issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end

      case (state_q)
         IF_FETCH: begin
            if (done_c) begin
               if_inst_d  = word_c;
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
               state_d    = IF_OUT;
            end
         end
         IF_OUT: begin
            if (!stall[STOP_OUT]) begin
               pc_d        = pc_q + ADDR_W'(INST_BYTES);
               if_valid_d  = 1'b0;
               issue_cnt_d = '0;
               state_d     = IF_FETCH;
            end
         end
         default: state_d = IF_FETCH;
      endcase

      // Redirect discards any completion or handoff happening in the same cycle.
      if (jump_en) begin
         pc_d        = jump_target;
         state_d     = IF_FETCH;
         issue_cnt_d = '0;
         if_valid_d  = 1'b0;
         if_inst_d   = if_inst_q;
         if_pc_d     = if_pc_q;
         flush_c     = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IF_FETCH;
         pc_q        <= RESET_PC;
         issue_cnt_q <= '0;
         if_pc_q     <= '0;
         if_inst_q   <= '0;
         if_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         issue_cnt_q <= issue_cnt_d;
         if_pc_q     <= if_pc_d;
         if_inst_q   <= if_inst_d;
         if_valid_q  <= if_valid_d;
      end
   end

   assign mem_addr  = mem_addr_c;
   assign mem_rd_en = issue_c;
   assign if_pc     = if_pc_q;
   assign if_inst   = if_inst_q;
   assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte-wide memory model, cycle-by-cycle expected issue and output values.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        jump_en;
   logic [31:0] jump_target;
   logic        mem_busy;
   logic [7:0]  mem_din;
   logic [31:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_valid;

   logic [7:0]  mem [0:511];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   // Byte returns in the cycle after its address is issued; garbage otherwise.
   always @(posedge clk) mem_din <= mem_rd_en ? mem[mem_addr[8:0]] : 8'hEE;

   if_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .jump_en     (jump_en),
      .jump_target (jump_target),
      .mem_busy    (mem_busy),
      .mem_din     (mem_din),
      .mem_addr    (mem_addr),
      .mem_rd_en   (mem_rd_en),
      .if_pc       (if_pc),
      .if_inst     (if_inst),
      .if_valid    (if_valid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [5:0] st, input logic busy, input logic je, input logic [31:0] jt);
      @(negedge clk);
      stall = st; mem_busy = busy; jump_en = je; jump_target = jt;
      #1;
   endtask

   task automatic chk_issue(input string tag, input logic en, input logic [31:0] addr);
      chk({tag, ".rd_en"}, 64'(mem_rd_en), 64'(en));
      chk({tag, ".addr"}, 64'(mem_addr), 64'(addr));
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] inst, input logic [31:0] pc);
      chk({tag, ".valid"}, 64'(if_valid), 64'(v));
      chk({tag, ".inst"}, 64'(if_inst), 64'(inst));
      chk({tag, ".pc"}, 64'(if_pc), 64'(pc));
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
      mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
      mem[4] = 8'h93; mem[5] = 8'h00; mem[6] = 8'h20; mem[7] = 8'h00;
      mem[8] = 8'h33; mem[9] = 8'h85; mem[10] = 8'hA5; mem[11] = 8'h00;
      mem[256] = 8'hB7; mem[257] = 8'h12; mem[258] = 8'h34; mem[259] = 8'h56;

      rst = 1'b1; stall = '0; mem_busy = 1'b0; jump_en = 1'b0; jump_target = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_out("reset", 1'b0, 32'h0, 32'h0);
      chk("reset.addr", 64'(mem_addr), 64'h0);

      // Baseline fetch from address 0
      @(negedge clk); rst = 1'b0; #1;
      chk_issue("c1", 1'b1, 32'd0);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c2", 1'b1, 32'd1);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c3", 1'b1, 32'd2);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c4", 1'b1, 32'd3);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c5", 1'b0, 32'd0);
      chk("c5.valid", 64'(if_valid), 64'd0);

      // Output held by stall[1] for three cycles
      cyc(6'b000010, 1'b0, 1'b0, 32'd0); chk_out("c6", 1'b1, 32'h00100513, 32'h0);
      chk("c6.rd_en", 64'(mem_rd_en), 64'd0);
      cyc(6'b000010, 1'b0, 1'b0, 32'd0); chk_out("c7", 1'b1, 32'h00100513, 32'h0);
      chk("c7.rd_en", 64'(mem_rd_en), 64'd0);
      cyc(6'b000010, 1'b0, 1'b0, 32'd0); chk_out("c8", 1'b1, 32'h00100513, 32'h0);
      chk("c8.rd_en", 64'(mem_rd_en), 64'd0);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_out("c9", 1'b1, 32'h00100513, 32'h0);

      // Handoff: pc=4, outputs keep last value with valid low; mem_busy after byte 1
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_out("c10", 1'b0, 32'h00100513, 32'h0);
      chk_issue("c10", 1'b1, 32'd4);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c11", 1'b1, 32'd5);
      cyc(6'd0, 1'b1, 1'b0, 32'd0); chk_issue("c12", 1'b0, 32'd4);
      cyc(6'd0, 1'b1, 1'b0, 32'd0); chk_issue("c13", 1'b0, 32'd4);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c14", 1'b1, 32'd6);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c15", 1'b1, 32'd7);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk("c16.valid", 64'(if_valid), 64'd0);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_out("c17", 1'b1, 32'h00200093, 32'h4);

      // stall[0] during FETCH with byte 0 in flight
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c18", 1'b1, 32'd8);
      cyc(6'b000111, 1'b0, 1'b0, 32'd0); chk("c19.rd_en", 64'(mem_rd_en), 64'd0);
      cyc(6'b000111, 1'b0, 1'b0, 32'd0); chk("c20.rd_en", 64'(mem_rd_en), 64'd0);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c21", 1'b1, 32'd9);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c22", 1'b1, 32'd10);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c23", 1'b1, 32'd11);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk("c24.valid", 64'(if_valid), 64'd0);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_out("c25", 1'b1, 32'h00A58533, 32'h8);

      // Redirect in the cycle byte 2 would issue
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c26", 1'b1, 32'd12);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c27", 1'b1, 32'd13);
      cyc(6'd0, 1'b0, 1'b1, 32'h100); chk("c28.rd_en", 64'(mem_rd_en), 64'd0);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c29", 1'b1, 32'h100);
      chk("c29.valid", 64'(if_valid), 64'd0);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c30", 1'b1, 32'h101);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c31", 1'b1, 32'h102);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c32", 1'b1, 32'h103);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk("c33.valid", 64'(if_valid), 64'd0);

      // Redirect coinciding with handoff: target wins over pc+4
      cyc(6'd0, 1'b0, 1'b1, 32'h100); chk_out("c34", 1'b1, 32'h563412B7, 32'h100);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_out("c35", 1'b0, 32'h563412B7, 32'h100);
      chk_issue("c35", 1'b1, 32'h100);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c36", 1'b1, 32'h101);

      // Reset pulse mid-fetch; byte from 0x101 returns after reset and must be ignored
      @(negedge clk); rst = 1'b1; #1;
      chk_out("c37rst", 1'b0, 32'h0, 32'h0);
      chk("c37rst.addr", 64'(mem_addr), 64'h0);
      #1 rst = 1'b0; #1;
      chk_issue("c37", 1'b1, 32'd0);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c38", 1'b1, 32'd1);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c39", 1'b1, 32'd2);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_issue("c40", 1'b1, 32'd3);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk("c41.valid", 64'(if_valid), 64'd0);
      cyc(6'd0, 1'b0, 1'b0, 32'd0); chk_out("c42", 1'b1, 32'h00100513, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
